remap_scheduler: RTL and testbench

Time-multiplexes the single tilt-to-LED `remapper` between two player input channels. Each channel delivers signed 16-bit tilt samples over a valid/ready handshake. The scheduler arbitrates round-robin and drives the shared remapper. It captures `board_posit`/`neg` per player and publishes both players' positions synchronously on a frame tick, so the LED display never shows a half-updated frame.

---
 rtl/remap_scheduler.sv | 140 ++++++++++++++
 tb/tb_remap_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/remap_scheduler.sv
// Round-robin scheduler sharing one tilt-to-LED remapper between two players,
// with per-player shadow results published together on a frame tick.
module remap_scheduler #(
  parameter int TICK_DIV = 50000,
  parameter int W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] p0_sample,
  input  logic         p0_valid,
  output logic         p0_ready,
  input  logic [W-1:0] p1_sample,
  input  logic         p1_valid,
  output logic         p1_ready,
  output logic [W-1:0] rm_in,
  input  logic [9:0]   rm_board_posit,
  input  logic         rm_neg,
  output logic [9:0]   p0_posit,
  output logic         p0_neg,
  output logic [9:0]   p1_posit,
  output logic         p1_neg,
  output logic         frame_tick,
  output logic         busy
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;

  state_t          state, state_next;
  logic            pending0, pending1;
  logic [W-1:0]    hold0, hold1;
  logic            grant, grant_next;
  logic            last_grant;
  logic [9:0]      shadow_posit0, shadow_posit1;
  logic            shadow_neg0, shadow_neg1;
  logic [CW-1:0]   count;
  logic            accept0, accept1;

  assign p0_ready   = !pending0;
  assign p1_ready   = !pending1;
  assign accept0    = p0_valid && !pending0;
  assign accept1    = p1_valid && !pending1;
  assign busy       = (state != IDLE);
  assign frame_tick = (count == LAST);

  // A pending flag clears only on its own capture edge; since ready is low
  // while pending, an accept and a clear never target the same player at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending0 <= 1'b0;
      pending1 <= 1'b0;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      if (accept0) begin
        hold0    <= p0_sample;
        pending0 <= 1'b1;
      end else if (state == CAPTURE && !grant) begin
        pending0 <= 1'b0;
      end
      if (accept1) begin
        hold1    <= p1_sample;
        pending1 <= 1'b1;
      end else if (state == CAPTURE && grant) begin
        pending1 <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (pending0 || pending1) begin
          state_next = DRIVE;
          if (pending0 && pending1) grant_next = !last_grant;
          else                      grant_next = pending1;
        end
      end
      DRIVE:   state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DRIVE gives the remapper a full cycle to settle before CAPTURE samples it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      rm_in         <= '0;
      shadow_posit0 <= '0;
      shadow_neg0   <= 1'b0;
      shadow_posit1 <= '0;
      shadow_neg1   <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (state == IDLE && state_next == DRIVE)
        rm_in <= grant_next ? hold1 : hold0;
      if (state == CAPTURE) begin
        last_grant <= grant;
        if (grant) begin
          shadow_posit1 <= rm_board_posit;
          shadow_neg1   <= rm_neg;
        end else begin
          shadow_posit0 <= rm_board_posit;
          shadow_neg0   <= rm_neg;
        end
      end
    end
  end

  // Publishing reads the pre-edge shadows, so a capture on the tick edge
  // waits for the following tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      p0_posit <= '0;
      p0_neg   <= 1'b0;
      p1_posit <= '0;
      p1_neg   <= 1'b0;
    end else begin
      if (count == LAST) begin
        count    <= '0;
        p0_posit <= shadow_posit0;
        p0_neg   <= shadow_neg0;
        p1_posit <= shadow_posit1;
        p1_neg   <= shadow_neg1;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_remap_scheduler.sv
// Directed bench for remap_scheduler with a wiring-only remapper stub
// (posit = rm_in[9:0], neg = rm_in[15]) and an 8-cycle frame.
module tb_remap_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] p0_sample, p1_sample;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [15:0] rm_in;
  logic [9:0]  rm_board_posit;
  logic        rm_neg;
  logic [9:0]  p0_posit, p1_posit;
  logic        p0_neg, p1_neg;
  logic        frame_tick;
  logic        busy;

  int vectors;
  int miscompares;
  int cyc;

  assign rm_board_posit = rm_in[9:0];
  assign rm_neg         = rm_in[15];

  remap_scheduler #(.TICK_DIV(8), .W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .p0_sample      (p0_sample),
    .p0_valid       (p0_valid),
    .p0_ready       (p0_ready),
    .p1_sample      (p1_sample),
    .p1_valid       (p1_valid),
    .p1_ready       (p1_ready),
    .rm_in          (rm_in),
    .rm_board_posit (rm_board_posit),
    .rm_neg         (rm_neg),
    .p0_posit       (p0_posit),
    .p0_neg         (p0_neg),
    .p1_posit       (p1_posit),
    .p1_neg         (p1_neg),
    .frame_tick     (frame_tick),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] s0, input logic v0,
                                input logic [15:0] s1, input logic v1);
    p0_sample = s0;
    p0_valid  = v0;
    p1_sample = s1;
    p1_valid  = v1;
  endtask

  // cyc counts edges since reset release, so the counter value is cyc % 8.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) check_output("frame_tick", {31'd0, frame_tick}, {31'd0, (cyc % 8) == 7});
  endtask

  task automatic run_to_publish();
    while ((cyc % 8) != 7) step();
    step();
  endtask

  logic [15:0] samples [10];
  int          sent, seen, last_accept;
  logic        prev_busy, acc;

  initial begin
    samples = '{16'd85, 16'd65, 16'd45, 16'd25, 16'd5,
                16'hFFF1, 16'hFFDD, 16'hFFC9, 16'hFFB5, 16'hFFA1};
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst = 1'b1;
    apply_stimulus(16'd0, 1'b0, 16'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_rm_in", {16'd0, rm_in}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_p0_posit", {22'd0, p0_posit}, 32'd0);
    check_output("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    #1;
    check_output("rel_p0_ready", {31'd0, p0_ready}, 32'd1);
    check_output("rel_p1_ready", {31'd0, p1_ready}, 32'd1);

    // Reset while p0=85 is in DRIVE: service aborted, nothing captured.
    apply_stimulus(16'd85, 1'b1, 16'd0, 1'b0);
    step();
    check_output("mid_p0_ready_low", {31'd0, p0_ready}, 32'd0);
    apply_stimulus(16'd85, 1'b0, 16'd0, 1'b0);
    step();
    check_output("mid_busy", {31'd0, busy}, 32'd1);
    check_output("mid_rm_in", {16'd0, rm_in}, 32'd85);
    rst = 1'b1;
    #1;
    check_output("mid_rst_rm_in", {16'd0, rm_in}, 32'd0);
    check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    #1;
    check_output("mid_rel_p0_ready", {31'd0, p0_ready}, 32'd1);
    run_to_publish();
    check_output("mid_no_shadow_posit", {22'd0, p0_posit}, 32'd0);
    check_output("mid_no_shadow_neg", {31'd0, p0_neg}, 32'd0);

    // Single sample p0=85.
    apply_stimulus(16'd85, 1'b1, 16'd0, 1'b0);
    step();
    check_output("s_ready_n", {31'd0, p0_ready}, 32'd0);
    check_output("s_busy_n", {31'd0, busy}, 32'd0);
    apply_stimulus(16'h1234, 1'b0, 16'd0, 1'b0);
    step();
    check_output("s_rm_in_n1", {16'd0, rm_in}, 32'd85);
    check_output("s_busy_n1", {31'd0, busy}, 32'd1);
    check_output("s_ready_n1", {31'd0, p0_ready}, 32'd0);
    step();
    check_output("s_busy_n2", {31'd0, busy}, 32'd1);
    check_output("s_ready_n2", {31'd0, p0_ready}, 32'd0);
    check_output("s_rm_in_n2", {16'd0, rm_in}, 32'd85);
    step();
    check_output("s_busy_n3", {31'd0, busy}, 32'd0);
    check_output("s_ready_n3", {31'd0, p0_ready}, 32'd1);
    check_output("s_not_yet_published", {22'd0, p0_posit}, 32'd0);
    run_to_publish();
    check_output("s_p0_posit", {22'd0, p0_posit}, 32'd85);
    check_output("s_p0_neg", {31'd0, p0_neg}, 32'd0);

    // Negative sample on p1: -20.
    apply_stimulus(16'd0, 1'b0, 16'hFFEC, 1'b1);
    step();
    apply_stimulus(16'd0, 1'b0, 16'd0, 1'b0);
    repeat (3) step();
    check_output("n_p1_ready", {31'd0, p1_ready}, 32'd1);
    run_to_publish();
    check_output("n_p1_posit", {22'd0, p1_posit}, 32'h3EC);
    check_output("n_p1_neg", {31'd0, p1_neg}, 32'd1);
    check_output("n_p0_posit_kept", {22'd0, p0_posit}, 32'd85);
    check_output("n_p0_neg_kept", {31'd0, p0_neg}, 32'd0);

    // First contention: last_grant starts at 1, so p0 goes first.
    apply_stimulus(16'd65, 1'b1, 16'd45, 1'b1);
    step();
    apply_stimulus(16'd0, 1'b0, 16'd0, 1'b0);
    step();
    check_output("c1_first", {16'd0, rm_in}, 32'd65);
    repeat (2) step();
    check_output("c1_p0_ready", {31'd0, p0_ready}, 32'd1);
    check_output("c1_p1_ready", {31'd0, p1_ready}, 32'd0);
    step();
    check_output("c1_second", {16'd0, rm_in}, 32'd45);
    check_output("c1_busy", {31'd0, busy}, 32'd1);
    repeat (2) step();
    check_output("c1_p1_done", {31'd0, p1_ready}, 32'd1);

    // p0 alone leaves last_grant=0, so the next contention goes to p1.
    apply_stimulus(16'd7, 1'b1, 16'd0, 1'b0);
    step();
    apply_stimulus(16'd0, 1'b0, 16'd0, 1'b0);
    repeat (3) step();
    apply_stimulus(16'd12, 1'b1, 16'd34, 1'b1);
    step();
    apply_stimulus(16'd0, 1'b0, 16'd0, 1'b0);
    step();
    check_output("c2_first_p1", {16'd0, rm_in}, 32'd34);
    repeat (3) step();
    check_output("c2_second_p0", {16'd0, rm_in}, 32'd12);
    repeat (2) step();
    run_to_publish();
    check_output("c_p0_posit", {22'd0, p0_posit}, 32'd12);
    check_output("c_p1_posit", {22'd0, p1_posit}, 32'd34);
    check_output("c_p1_neg", {31'd0, p1_neg}, 32'd0);

    // Capture lands exactly on the publish edge.
    repeat (4) step();
    apply_stimulus(16'd200, 1'b1, 16'd0, 1'b0);
    step();
    apply_stimulus(16'd0, 1'b0, 16'd0, 1'b0);
    repeat (3) step();
    check_output("t_capture_done", {31'd0, p0_ready}, 32'd1);
    check_output("t_old_value", {22'd0, p0_posit}, 32'd12);
    run_to_publish();
    check_output("t_new_value", {22'd0, p0_posit}, 32'd200);

    // Back-pressure: valid held high, junk data while not ready.
    sent = 0;
    seen = 0;
    last_accept = -100;
    prev_busy = busy;
    for (int c = 0; c < 80 && seen < 10; c++) begin
      if (sent < 10) begin
        p0_valid  = 1'b1;
        p0_sample = p0_ready ? samples[sent] : 16'($urandom);
      end else begin
        p0_valid = 1'b0;
      end
      acc = p0_ready && p0_valid;
      step();
      if (acc) begin
        if (sent > 0) check_output("bp_accept_gap", {31'd0, (cyc - last_accept) >= 3}, 32'd1);
        last_accept = cyc;
        sent++;
      end
      if (busy && !prev_busy) begin
        check_output("bp_rm_in", {16'd0, rm_in}, {16'd0, samples[seen]});
        seen++;
      end
      prev_busy = busy;
    end
    p0_valid = 1'b0;
    check_output("bp_sent", sent, 32'd10);
    check_output("bp_seen", seen, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
